// File: rtl/axis_cnt_gen_pkg.sv
// axis_cnt_gen_pkg: shared types and LFSR tap table for the AXI-stream counter/pattern source.
//   gen_state_e : IDLE / RUN / GAP / DONE
//   gen_mode_e  : MODE_INC / MODE_DEC / MODE_CONST / MODE_LFSR
//   lfsr_taps   : maximal-length Fibonacci tap mask for widths 2..64
package axis_cnt_gen_pkg;
    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} gen_state_e;
    typedef enum logic [1:0] {MODE_INC, MODE_DEC, MODE_CONST, MODE_LFSR} gen_mode_e;
    // Each byte of p is a 1-based tap position (0 = unused). Width 37 needs two extra taps (2,1).
    function automatic logic [63:0] lfsr_taps(int w);
        logic [31:0] p;
        logic [63:0] m;
        case (w)
            2: p = 32'h02010000;  3: p = 32'h03020000;  4: p = 32'h04030000;  5: p = 32'h05030000;
            6: p = 32'h06050000;  7: p = 32'h07060000;  8: p = 32'h08060504;  9: p = 32'h09050000;
            10: p = 32'h0A070000; 11: p = 32'h0B090000; 12: p = 32'h0C060401; 13: p = 32'h0D040301;
            14: p = 32'h0E050301; 15: p = 32'h0F0E0000; 16: p = 32'h100F0D04; 17: p = 32'h110E0000;
            18: p = 32'h120B0000; 19: p = 32'h13060201; 20: p = 32'h14110000; 21: p = 32'h15130000;
            22: p = 32'h16150000; 23: p = 32'h17120000; 24: p = 32'h18171611; 25: p = 32'h19160000;
            26: p = 32'h1A060201; 27: p = 32'h1B050201; 28: p = 32'h1C190000; 29: p = 32'h1D1B0000;
            30: p = 32'h1E060401; 31: p = 32'h1F1C0000; 32: p = 32'h20160201; 33: p = 32'h21140000;
            34: p = 32'h221B0201; 35: p = 32'h23210000; 36: p = 32'h24190000; 37: p = 32'h25050403;
            38: p = 32'h26060501; 39: p = 32'h27230000; 40: p = 32'h28261513; 41: p = 32'h29260000;
            42: p = 32'h2A291413; 43: p = 32'h2B2A2625; 44: p = 32'h2C2B1211; 45: p = 32'h2D2C2A29;
            46: p = 32'h2E2D1A19; 47: p = 32'h2F2A0000; 48: p = 32'h302F1514; 49: p = 32'h31280000;
            50: p = 32'h32311817; 51: p = 32'h33322423; 52: p = 32'h34310000; 53: p = 32'h35342625;
            54: p = 32'h36351211; 55: p = 32'h371F0000; 56: p = 32'h38372322; 57: p = 32'h39320000;
            58: p = 32'h3A270000; 59: p = 32'h3B3A2625; 60: p = 32'h3C3B0000; 61: p = 32'h3D3C2E2D;
            62: p = 32'h3E3D0605; 63: p = 32'h3F3E0000; 64: p = 32'h403F3D3C;
            default: p = 32'h0;
        endcase
        m = (w == 37) ? 64'h3 : 64'h0;
        for (int i = 0; i < 4; i++)
            if (p[8*i +: 8] != 8'd0) m = m | (64'd1 << (p[8*i +: 8] - 8'd1));
        return m;
    endfunction
endpackage

// File: rtl/axis_cnt_gen_datapath.sv
// axis_cnt_gen_datapath: combinational start value and next-beat data for the pattern source.
//   cfg_mode/cfg_seed : raw config, used for the start value (LFSR seed 0 becomes 1)
//   mode/seed         : latched config of the current run
//   data              : current beat data
//   init / next       : start value / data after a handshake
module axis_cnt_gen_datapath
    import axis_cnt_gen_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic [1:0]       cfg_mode,
    input  logic [DSIZE-1:0] cfg_seed,
    input  logic [1:0]       mode,
    input  logic [DSIZE-1:0] seed,
    input  logic [DSIZE-1:0] data,
    output logic [DSIZE-1:0] init,
    output logic [DSIZE-1:0] next
);
    localparam logic [DSIZE-1:0] TAPS = DSIZE'(lfsr_taps(DSIZE));
    gen_mode_e m, cm;
    assign m = gen_mode_e'(mode);
    assign cm = gen_mode_e'(cfg_mode);
    always_comb begin
        init = (cm == MODE_LFSR && cfg_seed == '0) ? DSIZE'(1) : cfg_seed;
        next = m == MODE_INC   ? data + DSIZE'(1) :
               m == MODE_DEC   ? data - DSIZE'(1) :
               m == MODE_CONST ? seed :
                                 {data[DSIZE-2:0], ^(data & TAPS)};
    end
endmodule

// File: rtl/axis_cnt_gen.sv
// axis_cnt_gen: framed AXI-stream counter/pattern source with frame length, count, gap and data mode.
//   clock, rst (sync, active-high); start pulse / stop level control a run
//   cfg_len, cfg_num, cfg_gap, cfg_mode, cfg_seed : sampled only on an accepted start
//   axis_tdata/tvalid/tlast/tready : AXI-stream master; enable high outside IDLE
//   frame_cnt : frames completed in the current run
//   AXIS_CNT_GEN_STALL_STAT_EN adds stall_cnt (saturating count of tvalid & !tready cycles)
module axis_cnt_gen
    import axis_cnt_gen_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int LEN_W = 10,
    parameter int NUM_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [NUM_W-1:0] cfg_num,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [1:0]       cfg_mode,
    input  logic [DSIZE-1:0] cfg_seed,
    output logic [DSIZE-1:0] axis_tdata,
    output logic             axis_tvalid,
    output logic             axis_tlast,
    input  logic             axis_tready,
    output logic             enable,
    output logic [NUM_W-1:0] frame_cnt
`ifdef AXIS_CNT_GEN_STALL_STAT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);
    gen_state_e state_q, state_d;
    logic [LEN_W-1:0] len_q, beat_q;
    logic [NUM_W-1:0] num_q, fc_next;
    logic [GAP_W-1:0] gap_q, gcnt_q;
    logic [1:0] mode_q;
    logic [DSIZE-1:0] seed_q, data_q, data_init, data_next;
    logic stop_q, go, hs, last, frame_end, gap_end;

    assign go = state_q == IDLE && start;
    assign hs = state_q == RUN && axis_tready;
    // len 0 and 1 both mean single-beat frames
    assign last = len_q <= LEN_W'(1) || beat_q == len_q - LEN_W'(1);
    assign frame_end = hs && last;
    assign fc_next = frame_cnt + NUM_W'(1);
    assign gap_end = state_q == GAP && gcnt_q == gap_q - GAP_W'(1);
    assign axis_tdata = data_q;

    axis_cnt_gen_datapath #(.DSIZE(DSIZE)) u_dp (
        .cfg_mode(cfg_mode),
        .cfg_seed(cfg_seed),
        .mode(mode_q),
        .seed(seed_q),
        .data(data_q),
        .init(data_init),
        .next(data_next)
    );

    always_ff @(posedge clock) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = start ? RUN : IDLE;
            RUN:  if (frame_end) state_d = ((num_q != '0 && fc_next == num_q) || stop) ? DONE :
                                           gap_q != '0 ? GAP : RUN;
            GAP:  if (gap_end) state_d = (stop_q || stop) ? DONE : RUN;
            DONE: state_d = IDLE;
        endcase
    end

    always_comb begin
        axis_tvalid = state_q == RUN;
        axis_tlast = state_q == RUN && last;
        enable = state_q != IDLE;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            {len_q, num_q, gap_q, mode_q, seed_q} <= '0;
            {data_q, beat_q, frame_cnt, gcnt_q, stop_q} <= '0;
        end else begin
            if (go) begin
                {len_q, num_q, gap_q, mode_q, seed_q} <= {cfg_len, cfg_num, cfg_gap, cfg_mode, cfg_seed};
                data_q <= data_init;
                beat_q <= '0;
                frame_cnt <= '0;
            end
            if (hs) begin
                data_q <= data_next;
                beat_q <= last ? '0 : beat_q + LEN_W'(1);
                if (last) frame_cnt <= fc_next;
            end
            gcnt_q <= state_q == GAP ? gcnt_q + GAP_W'(1) : '0;
            // a stop seen at any point of the gap ends the run when the gap expires
            stop_q <= state_q == GAP && (stop_q || stop);
        end
    end

`ifdef AXIS_CNT_GEN_STALL_STAT_EN
    always_ff @(posedge clock) begin
        if (rst || go) stall_cnt <= '0;
        else if (axis_tvalid && !axis_tready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: doc/axis_cnt_gen.md
Name: axis_cnt_gen

Overview:
- Parametrised AXI-stream counter/pattern source; next generation of the free-running counter stub in the test-unit modules.
- Emits framed beats (tlast per frame) with a programmable frame length, frame count, inter-frame gap and data mode.
- Drives an enable flag while active.
- Used as a stimulus source in test units and as a link-bring-up generator ahead of downstream stream blocks.

Parameters:
- DSIZE, 8: tdata width in bits, 2..64.
- LEN_W, 10: width of the frame-length and beat counters.
- NUM_W, 8: width of the frame-count field.
- GAP_W, 4: width of the inter-frame gap field.

Ports:
- clock  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; samples the config and begins a run.
- stop  in  1  level; ends the run at the next frame boundary.
- cfg_len  in  LEN_W  beats per frame; 0 is treated as 1.
- cfg_num  in  NUM_W  frames per run; 0 means endless.
- cfg_gap  in  GAP_W  idle cycles between frames.
- cfg_mode  in  2  data mode: 00 inc, 01 dec, 10 const, 11 LFSR.
- cfg_seed  in  DSIZE  initial data value; LFSR seed.
- axis_tdata  out  DSIZE  stream data.
- axis_tvalid  out  1  stream valid.
- axis_tlast  out  1  last beat of the frame.
- axis_tready  in  1  downstream ready.
- enable  out  1  high in every state except IDLE.
- frame_cnt  out  NUM_W  count of frames completed in the current run.

Behaviour:
- Reset is synchronous, active-high. All outputs reset to 0; state resets to IDLE.
- States:
  - IDLE: start=1 latches all cfg_* (shadow registers), clears frame_cnt and the beat counter, sets data to cfg_seed, then goes to RUN. start in any other state is ignored.
  - RUN: axis_tvalid=1. On handshake (tvalid & tready):
    - beat counter increments and data advances per mode.
    - when the beat is last, frame_cnt increments.
    - then go to DONE if (num!=0 and frame_cnt+1==num) or stop=1; else GAP if gap!=0; else stay in RUN for the next frame.
  - GAP: tvalid=0 for exactly gap cycles, then RUN.
  - DONE: tvalid=0, enable=1 for one cycle, then IDLE.
- First tvalid appears on the cycle after the start pulse (1-cycle latency).
- AXIS rules:
  - tdata and tlast are held stable while tvalid & !tready.
  - tvalid is never dropped without a handshake.
  - stop asserted mid-frame does not truncate the frame; stop is sampled only on the last-beat handshake.
  - stop asserted during GAP forces DONE at the end of the gap.
- tlast = (beat counter == len-1). With len 0 or 1, tlast is asserted on every beat.
- Data advance occurs only on handshake and continues across frames; it is reseeded only by start.
  - inc/dec wrap modulo 2^DSIZE.
  - const holds cfg_seed.
  - LFSR is a Fibonacci, maximal-length LFSR; taps are per DSIZE from the package.
  - A seed of 0 in LFSR mode is replaced by 1.
- frame_cnt:
  - wraps modulo 2^NUM_W when num=0 (endless).
  - holds its value from DONE until the next start.
- Config inputs are don't-care outside the start cycle.

Optional Feature:
- Macro: AXIS_CNT_GEN_STALL_STAT_EN.
- Defined: adds output stall_cnt (32 bits). It counts cycles with tvalid & !tready, saturates at 2^32-1, and is cleared by start and by rst.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package axis_cnt_gen_pkg holds:
  - enum gen_state_e {IDLE, RUN, GAP, DONE}.
  - enum gen_mode_e {MODE_INC, MODE_DEC, MODE_CONST, MODE_LFSR}.
  - function lfsr_taps(int w), returning the tap mask for 2..64.
- One sub-module, axis_cnt_gen_datapath: combinational next-data function over mode/seed; the FSM and counters stay in the top.

Test Plan:
- len=4, num=2, gap=0, mode inc, seed 8'hFE, tready=1 -> beats FE,FF,00,01 | 02,03,04,05. tlast on beats 4 and 8; frame_cnt=2; enable drops 1 cycle after DONE.
- len=3, num=1, tready toggling 1,0,0,1,1 -> each beat held stable through stalls; exactly 3 handshakes; stall_cnt=2 with the macro defined.
- len=5, num=0, gap=2, stop asserted on beat 2 of frame 3 -> frame 3 completes all 5 beats, no further tvalid, frame_cnt=3.
- mode LFSR, DSIZE=8, seed 0 -> first beat 8'h01; 255 beats before repeat; no 00 value.
- rst asserted mid-frame (beat 2 of len 8) -> next cycle tvalid=0, enable=0, frame_cnt=0; start after reset begins from cfg_seed.
- start pulsed during RUN with different cfg -> ignored; output stream unchanged.
